traffic_light_timed_controller: RTL

Two-road (main/side) intersection controller with per-phase programmable durations, all-red clearance intervals, a latched side-road/pedestrian request, and a night flashing mode. Phase timing advances on an external `tick` enable from a shared prescaler, so one instance works at any system clock. It replaces the fixed one-clock-per-state sequencer in the intersection subsystem. It drives the six lamp outputs plus status for the supervisor.

---
 rtl/traffic_light_timed_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/traffic_light_timed_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_timed_controller
//
// Two-road (main/side) intersection sequencer. It provides programmable phase
// durations counted in `tick` units, all-red clearance before each green, a
// latched side-road request, and a night flashing mode. Main green is the
// resting phase. It is left only when a side request is pending and at least
// MAIN_GREEN_T ticks have elapsed.
//
// Parameters
//   CNT_W         phase timer width; every duration must be <= 2**CNT_W
//   MAIN_GREEN_T  minimum main-green duration (ticks)
//   SIDE_GREEN_T  side-green duration (ticks)
//   YELLOW_T      yellow duration for either road (ticks)
//   ALLRED_T      all-red clearance duration (ticks)
//   FLASH_T       flash half-period (ticks)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tick         one-cycle timing enable from a shared prescaler
//   button       side-road / pedestrian request (level or pulse)
//   flash_en     night flashing mode request
//   main_*       main-road lamps (registered)
//   side_*       side-road lamps (registered)
//   phase        current state code (0..6)
//   req_pending  latched side request not yet served
// -----------------------------------------------------------------------------
module traffic_light_timed_controller #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MAIN_GREEN_T = 20,
  parameter int unsigned SIDE_GREEN_T = 10,
  parameter int unsigned YELLOW_T     = 4,
  parameter int unsigned ALLRED_T     = 2,
  parameter int unsigned FLASH_T      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       button,
  input  logic       flash_en,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic [2:0] phase,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    ALLRED_M    = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALLRED_S    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    FLASH       = 3'd6
  } state_t;

  // Timer load value for a duration. A duration of 0 behaves like 1 tick.
  function automatic logic [CNT_W-1:0] load_val(input int unsigned dur);
    if (dur <= 1) return '0;
    return CNT_W'(dur - 1);
  endfunction

  localparam logic [CNT_W-1:0] LD_MAIN_GREEN = load_val(MAIN_GREEN_T);
  localparam logic [CNT_W-1:0] LD_SIDE_GREEN = load_val(SIDE_GREEN_T);
  localparam logic [CNT_W-1:0] LD_YELLOW     = load_val(YELLOW_T);
  localparam logic [CNT_W-1:0] LD_ALLRED     = load_val(ALLRED_T);
  localparam logic [CNT_W-1:0] LD_FLASH      = load_val(FLASH_T);

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      MAIN_GREEN:               return LD_MAIN_GREEN;
      MAIN_YELLOW, SIDE_YELLOW: return LD_YELLOW;
      SIDE_GREEN:               return LD_SIDE_GREEN;
      FLASH:                    return LD_FLASH;
      default:                  return LD_ALLRED;
    endcase
  endfunction

  // Lamp vector {main_red, main_yellow, main_green, side_red, side_yellow, side_green}.
  function automatic logic [5:0] lamps_for(input state_t s, input logic b);
    case (s)
      MAIN_GREEN:  return 6'b001_100;
      MAIN_YELLOW: return 6'b010_100;
      SIDE_GREEN:  return 6'b100_001;
      SIDE_YELLOW: return 6'b100_010;
      FLASH:       return {1'b0, b, 1'b0, b, 2'b00};
      default:     return 6'b100_100;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             blink, blink_nxt;
  logic [5:0]       lamps;
  logic             expired;
  logic             enter_side;

  assign expired    = tick && (timer == '0);
  assign enter_side = (state_nxt == SIDE_GREEN) && (state != SIDE_GREEN);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    blink_nxt = blink;
    if (tick && (timer != '0)) timer_nxt = timer - 1'b1;

    if (flash_en) begin
      if (state != FLASH) begin
        // Enter flashing immediately from any phase, no clearance.
        state_nxt = FLASH;
        timer_nxt = LD_FLASH;
        blink_nxt = 1'b1;
      end else if (expired) begin
        timer_nxt = LD_FLASH;
        blink_nxt = ~blink;
      end
    end else begin
      case (state)
        ALLRED_M:    if (expired) state_nxt = MAIN_GREEN;
        // Main green rests at timer 0 until a request is pending. The next
        // tick after that is an expiry.
        MAIN_GREEN:  if (expired && req_pending) state_nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (expired) state_nxt = ALLRED_S;
        ALLRED_S:    if (expired) state_nxt = SIDE_GREEN;
        SIDE_GREEN:  if (expired) state_nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (expired) state_nxt = ALLRED_M;
        default:     state_nxt = ALLRED_M;  // leaving FLASH, or illegal code 7
      endcase
      if (state_nxt != state) timer_nxt = load_for(state_nxt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALLRED_M;
      timer       <= LD_ALLRED;
      blink       <= 1'b0;
      req_pending <= 1'b0;
      lamps       <= 6'b100_100;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      blink       <= blink_nxt;
      // Set beats clear when the button is high on the SIDE_GREEN entry clock.
      req_pending <= button | (req_pending & ~enter_side);
      lamps       <= lamps_for(state_nxt, blink_nxt);
    end
  end

  assign {main_red, main_yellow, main_green, side_red, side_yellow, side_green} = lamps;
  assign phase = state;

endmodule
